// File: rtl/dmem_port_arbiter_if.sv
// Requester, response and RAM-side signal bundle for dmem_port_arbiter.
// slave = arbiter view, master = requester/RAM view.
interface dmem_port_arbiter_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);
    logic          req_valid0, req_valid1;
    logic          req_we0,    req_we1;
    logic          req_lock0,  req_lock1;
    logic [AW-1:0] req_addr0,  req_addr1;
    logic [DW-1:0] req_wdata0, req_wdata1;
    logic          req_ready0, req_ready1;
    logic          rsp_valid0, rsp_valid1;
    logic [DW-1:0] rsp_rdata0, rsp_rdata1;
    logic          preempt0_o, preempt1_o;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  req_valid0, req_valid1, req_we0, req_we1, req_lock0, req_lock1,
        input  req_addr0, req_addr1, req_wdata0, req_wdata1, mem_rdata,
        output req_ready0, req_ready1, rsp_valid0, rsp_valid1, rsp_rdata0, rsp_rdata1,
        output preempt0_o, preempt1_o, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req_valid0, req_valid1, req_we0, req_we1, req_lock0, req_lock1,
        output req_addr0, req_addr1, req_wdata0, req_wdata1, mem_rdata,
        input  req_ready0, req_ready1, rsp_valid0, rsp_valid1, rsp_rdata0, rsp_rdata1,
        input  preempt0_o, preempt1_o, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Two-port arbiter in front of the single-port data RAM, with bounded bus lock.
// Define DMEM_ARB_RR_EN for round-robin tie breaking; default is port 0 fixed priority.
module dmem_port_arbiter #(
    parameter int unsigned AW       = 32,
    parameter int unsigned DW       = 32,
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic                clk,
    input  logic                reset,
    dmem_port_arbiter_if.slave  bus
);
    localparam int unsigned   HW       = 8;
    localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);
    localparam logic [HW-1:0] HOLD_SAT = '1;

    typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_e;

    state_e        state_q, state_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          last_gnt_q, last_gnt_d;
    logic          rsp_valid0_q, rsp_valid0_d, rsp_valid1_q, rsp_valid1_d;
    logic [DW-1:0] rsp_rdata0_q, rsp_rdata0_d, rsp_rdata1_q, rsp_rdata1_d;
    logic          preempt0_q, preempt0_d, preempt1_q, preempt1_d;
    logic          gnt0_c, gnt1_c, tie_win1_c;
    logic [AW-1:0] mem_addr_c;

    // A preempted owner always hands the next tie to the other port (last_gnt is the old owner).
`ifdef DMEM_ARB_RR_EN
    assign tie_win1_c = ~last_gnt_q;
`else
    assign tie_win1_c = (preempt0_q | preempt1_q) & ~last_gnt_q;
`endif

    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        last_gnt_d   = last_gnt_q;
        rsp_valid0_d = 1'b0;
        rsp_valid1_d = 1'b0;
        rsp_rdata0_d = rsp_rdata0_q;
        rsp_rdata1_d = rsp_rdata1_q;
        preempt0_d   = 1'b0;
        preempt1_d   = 1'b0;
        gnt0_c       = 1'b0;
        gnt1_c       = 1'b0;

        case (state_q)
            IDLE: begin
                hold_d = '0;
                if (bus.req_valid0 && bus.req_valid1) begin
                    gnt1_c = tie_win1_c;
                    gnt0_c = ~tie_win1_c;
                end else begin
                    gnt0_c = bus.req_valid0;
                    gnt1_c = bus.req_valid1;
                end
                if (gnt0_c && bus.req_lock0)      state_d = OWN0;
                else if (gnt1_c && bus.req_lock1) state_d = OWN1;
            end
            OWN0: begin
                if (bus.req_valid1 && hold_q >= HOLD_MAX) begin
                    state_d    = IDLE;
                    preempt0_d = 1'b1;
                end else begin
                    gnt0_c = bus.req_valid0;
                    if (gnt0_c && !bus.req_lock0)               state_d = IDLE;
                    else if (bus.req_valid1 && hold_q != HOLD_SAT) hold_d = hold_q + HW'(1);
                end
            end
            OWN1: begin
                if (bus.req_valid0 && hold_q >= HOLD_MAX) begin
                    state_d    = IDLE;
                    preempt1_d = 1'b1;
                end else begin
                    gnt1_c = bus.req_valid1;
                    if (gnt1_c && !bus.req_lock1)               state_d = IDLE;
                    else if (bus.req_valid0 && hold_q != HOLD_SAT) hold_d = hold_q + HW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (!reset) begin
            gnt0_c = 1'b0;
            gnt1_c = 1'b0;
        end

        // Reads capture the combinational RAM output at the accepting edge.
        if (gnt0_c) begin
            last_gnt_d = 1'b0;
            if (!bus.req_we0) begin
                rsp_valid0_d = 1'b1;
                rsp_rdata0_d = bus.mem_rdata;
            end
        end
        if (gnt1_c) begin
            last_gnt_d = 1'b1;
            if (!bus.req_we1) begin
                rsp_valid1_d = 1'b1;
                rsp_rdata1_d = bus.mem_rdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            hold_q       <= '0;
            last_gnt_q   <= 1'b1;
            rsp_valid0_q <= 1'b0;
            rsp_valid1_q <= 1'b0;
            rsp_rdata0_q <= '0;
            rsp_rdata1_q <= '0;
            preempt0_q   <= 1'b0;
            preempt1_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            last_gnt_q   <= last_gnt_d;
            rsp_valid0_q <= rsp_valid0_d;
            rsp_valid1_q <= rsp_valid1_d;
            rsp_rdata0_q <= rsp_rdata0_d;
            rsp_rdata1_q <= rsp_rdata1_d;
            preempt0_q   <= preempt0_d;
            preempt1_q   <= preempt1_d;
        end
    end

    assign mem_addr_c     = gnt1_c ? bus.req_addr1 : bus.req_addr0;
    assign bus.mem_addr   = mem_addr_c;
    assign bus.mem_wdata  = gnt1_c ? bus.req_wdata1 : bus.req_wdata0;
    assign bus.mem_we     = (gnt0_c & bus.req_we0) | (gnt1_c & bus.req_we1);
    assign bus.req_ready0 = gnt0_c;
    assign bus.req_ready1 = gnt1_c;
    // A response pending when reset arrives is suppressed immediately.
    assign bus.rsp_valid0 = rsp_valid0_q & reset;
    assign bus.rsp_valid1 = rsp_valid1_q & reset;
    assign bus.rsp_rdata0 = rsp_rdata0_q;
    assign bus.rsp_rdata1 = rsp_rdata1_q;
    assign bus.preempt0_o = preempt0_q;
    assign bus.preempt1_o = preempt1_q;
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: directed vector table, lock/preempt sequences and
// random traffic against a transaction-level model of ownership and RAM contents.
module tb_dmem_port_arbiter;
    localparam int unsigned AW       = 32;
    localparam int unsigned DW       = 32;
    localparam int unsigned MAX_HOLD = 8;
`ifdef DMEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk;
    logic reset;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    dmem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    dmem_port_arbiter #(.AW(AW), .DW(DW), .MAX_HOLD(MAX_HOLD)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Small RAM with combinational read
    logic [DW-1:0] ram [16];
    assign bus.mem_rdata = ram[bus.mem_addr[5:2]];
    always @(posedge clk) if (bus.mem_we) ram[bus.mem_addr[5:2]] <= bus.mem_wdata;

    int n_vec, n_bad, cyc;

    // Reference model state: who owns the bus, how long the other side has waited
    int            m_owner, m_wait, m_handoff, m_last;
    bit            m_rv  [2];
    bit            m_pre [2];
    logic [DW-1:0] m_rd  [2];
    logic [DW-1:0] m_ram [16];

    // DUT values observed in the most recent step
    bit            last_r0, last_r1, last_pre1, last_rv0;
    logic [DW-1:0] last_rd0;

    function automatic void chk(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endfunction

    task automatic model_reset();
        m_owner = -1; m_wait = 0; m_handoff = -1; m_last = 1;
        for (int i = 0; i < 2; i++) begin
            m_rv[i] = 1'b0; m_pre[i] = 1'b0; m_rd[i] = '0;
        end
    endtask

    task automatic step(input bit rst,
                        input bit v0, input bit we0, input bit lk0,
                        input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                        input bit v1, input bit we1, input bit lk1,
                        input logic [AW-1:0] a1, input logic [DW-1:0] d1);
        bit v[2], we[2], lk[2];
        logic [AW-1:0] a[2];
        logic [DW-1:0] d[2];
        int g;
        bit forced;
        bit exp_we;
        v[0] = v0; we[0] = we0; lk[0] = lk0; a[0] = a0; d[0] = d0;
        v[1] = v1; we[1] = we1; lk[1] = lk1; a[1] = a1; d[1] = d1;

        reset          = rst;
        bus.req_valid0 = v0; bus.req_we0 = we0; bus.req_lock0 = lk0;
        bus.req_addr0  = a0; bus.req_wdata0 = d0;
        bus.req_valid1 = v1; bus.req_we1 = we1; bus.req_lock1 = lk1;
        bus.req_addr1  = a1; bus.req_wdata1 = d1;
        #1;

        chk("rsp_valid0", DW'(bus.rsp_valid0), DW'(m_rv[0] && rst));
        chk("rsp_valid1", DW'(bus.rsp_valid1), DW'(m_rv[1] && rst));
        chk("rsp_rdata0", bus.rsp_rdata0, m_rd[0]);
        chk("rsp_rdata1", bus.rsp_rdata1, m_rd[1]);
        chk("preempt0",   DW'(bus.preempt0_o), DW'(m_pre[0]));
        chk("preempt1",   DW'(bus.preempt1_o), DW'(m_pre[1]));

        // Expected grant this cycle
        g = -1; forced = 1'b0;
        if (rst) begin
            if (m_owner < 0) begin
                if (v[0] && v[1]) g = (m_handoff >= 0) ? m_handoff : (RR ? 1 - m_last : 0);
                else if (v[0])    g = 0;
                else if (v[1])    g = 1;
            end else if (v[1 - m_owner] && m_wait >= int'(MAX_HOLD)) begin
                forced = 1'b1;
            end else if (v[m_owner]) begin
                g = m_owner;
            end
        end
        exp_we = (g >= 0) ? we[g] : 1'b0;

        chk("ready0", DW'(bus.req_ready0), DW'(g == 0));
        chk("ready1", DW'(bus.req_ready1), DW'(g == 1));
        chk("mem_we", DW'(bus.mem_we), DW'(exp_we));
        if (g >= 0) begin
            chk("mem_addr",  bus.mem_addr,  a[g]);
            chk("mem_wdata", bus.mem_wdata, d[g]);
        end

        last_r0   = bus.req_ready0;
        last_r1   = bus.req_ready1;
        last_pre1 = bus.preempt1_o;
        last_rv0  = bus.rsp_valid0;
        last_rd0  = bus.rsp_rdata0;

        // Advance the model to the state after this edge
        if (!rst) begin
            model_reset();
        end else begin
            m_pre[0] = 1'b0; m_pre[1] = 1'b0; m_rv[0] = 1'b0; m_rv[1] = 1'b0;
            if (forced) begin
                m_pre[m_owner] = 1'b1;
                m_handoff      = 1 - m_owner;
                m_owner        = -1;
            end else begin
                m_handoff = -1;
                if (m_owner >= 0) begin
                    if (g == m_owner && !lk[g])                   m_owner = -1;
                    else if (v[1 - m_owner] && m_wait < 255)       m_wait++;
                end else if (g >= 0 && lk[g]) begin
                    m_owner = g;
                    m_wait  = 0;
                end
                if (g >= 0) begin
                    m_last = g;
                    if (we[g]) m_ram[a[g][5:2]] = d[g];
                    else begin
                        m_rv[g] = 1'b1;
                        m_rd[g] = m_ram[a[g][5:2]];
                    end
                end
            end
        end

        @(negedge clk);
        cyc++;
    endtask

    typedef struct {
        bit rst;
        bit v0, we0, lk0; logic [AW-1:0] a0; logic [DW-1:0] d0;
        bit v1, we1, lk1; logic [AW-1:0] a1; logic [DW-1:0] d1;
        bit e_r0, e_r1, e_we;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input bit rst,
                       input bit v0, input bit we0, input bit lk0,
                       input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                       input bit v1, input bit we1, input bit lk1,
                       input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                       input bit e_r0, input bit e_r1, input bit e_we);
        vec_t t;
        t.rst = rst;
        t.v0 = v0; t.we0 = we0; t.lk0 = lk0; t.a0 = a0; t.d0 = d0;
        t.v1 = v1; t.we1 = we1; t.lk1 = lk1; t.a1 = a1; t.d1 = d1;
        t.e_r0 = e_r0; t.e_r1 = e_r1; t.e_we = e_we;
        tbl.push_back(t);
    endtask

    initial begin
        int cnt1;
        bit pre_early;
        n_vec = 0; n_bad = 0; cyc = 0;
        for (int i = 0; i < 16; i++) begin
            ram[i]   = '0;
            m_ram[i] = '0;
        end
        model_reset();

        reset = 1'b0;
        bus.req_valid0 = 1'b0; bus.req_we0 = 1'b0; bus.req_lock0 = 1'b0;
        bus.req_addr0  = '0;   bus.req_wdata0 = '0;
        bus.req_valid1 = 1'b0; bus.req_we1 = 1'b0; bus.req_lock1 = 1'b0;
        bus.req_addr1  = '0;   bus.req_wdata1 = '0;
        @(negedge clk);

        // rst  v0 we lk a0    d0            v1 we lk a1    d1            r0 r1 we
        for (int i = 0; i < 3; i++)
            add(0, 1, 0, 0, 'h10, '0,           1, 0, 0, 'h20, '0,           0, 0, 0);
        add(1, 1, 0, 0, 'h10, '0,               1, 0, 0, 'h20, '0,           1, 0, 0);
        add(1, 1, 1, 0, 'h10, 32'hDEADBEEF,     0, 0, 0, 'h20, '0,           1, 0, 1);
        add(1, 1, 0, 0, 'h10, '0,               0, 0, 0, 'h20, '0,           1, 0, 0);
        add(1, 0, 0, 0, 'h10, '0,               1, 1, 0, 'h20, 32'h12345678, 0, 1, 1);
        for (int i = 0; i < 4; i++)
            add(1, 1, 0, 0, 'h10, '0,           1, 0, 0, 'h20, '0,
                RR ? (i % 2 == 0) : 1'b1, RR ? (i % 2 == 1) : 1'b0, 0);
        add(1, 0, 0, 0, 'h10, '0,               0, 0, 0, 'h20, '0,           0, 0, 0);
        for (int i = 0; i < 3; i++)
            add(1, 0, 0, 0, 'h10, '0,           1, 0, 1, 'h24, '0,           0, 1, 0);
        add(1, 0, 0, 0, 'h10, '0,               1, 0, 0, 'h24, '0,           0, 1, 0);
        add(1, 1, 0, 0, 'h10, '0,               0, 0, 0, 'h24, '0,           1, 0, 0);

        foreach (tbl[i]) begin
            step(tbl[i].rst, tbl[i].v0, tbl[i].we0, tbl[i].lk0, tbl[i].a0, tbl[i].d0,
                 tbl[i].v1, tbl[i].we1, tbl[i].lk1, tbl[i].a1, tbl[i].d1);
            chk("tbl_ready0", DW'(last_r0), DW'(tbl[i].e_r0));
            chk("tbl_ready1", DW'(last_r1), DW'(tbl[i].e_r1));
            if (i == 6) begin
                chk("wr_then_rd_valid", DW'(last_rv0), DW'(1'b1));
                chk("wr_then_rd_data",  last_rd0, 32'hDEADBEEF);
            end
        end

        // Port 1 locks, port 0 waits: 8 granted cycles, a stolen cycle, then handoff
        step(1, 0, 0, 0, 'h10, '0, 1, 0, 1, 'h24, '0);
        cnt1 = 0; pre_early = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step(1, 1, 0, 0, 'h10, '0, 1, 0, 1, 'h24, '0);
            cnt1 += int'(last_r1);
            pre_early |= last_pre1;
        end
        chk("lock_grants_before_release", DW'(cnt1), DW'(8));
        chk("no_early_preempt", DW'(pre_early), DW'(1'b0));
        step(1, 1, 0, 0, 'h10, '0, 1, 0, 1, 'h24, '0);
        chk("release_cycle_ready1", DW'(last_r1), DW'(1'b0));
        step(1, 1, 0, 0, 'h10, '0, 1, 0, 1, 'h24, '0);
        chk("preempt1_pulse", DW'(last_pre1), DW'(1'b1));
        chk("handoff_ready0", DW'(last_r0), DW'(1'b1));
        step(1, 1, 0, 0, 'h10, '0, 1, 0, 0, 'h24, '0);
        step(1, 0, 0, 0, 'h10, '0, 0, 0, 0, 'h24, '0);
        chk("preempt1_single", DW'(last_pre1), DW'(1'b0));

        // Reset right after a locked read accept
        step(1, 1, 0, 1, 'h10, '0, 0, 0, 0, 'h24, '0);
        step(0, 0, 0, 0, 'h10, '0, 0, 0, 0, 'h24, '0);
        chk("rst_drops_rsp", DW'(last_rv0), DW'(1'b0));
        step(1, 0, 0, 0, 'h10, '0, 1, 0, 0, 'h24, '0);
        chk("rst_back_to_idle", DW'(last_r1), DW'(1'b1));
        chk("rst_no_late_rsp", DW'(last_rv0), DW'(1'b0));

        // Random traffic
        for (int n = 0; n < 1500; n++) begin
            logic [AW-1:0] ra0, ra1;
            ra0 = AW'($urandom_range(0, 15) * 4);
            ra1 = AW'($urandom_range(0, 15) * 4);
            step($urandom_range(0, 99) != 0,
                 $urandom_range(0, 99) < 65, $urandom_range(0, 99) < 40,
                 $urandom_range(0, 99) < 35, ra0, DW'($urandom),
                 $urandom_range(0, 99) < 65, $urandom_range(0, 99) < 40,
                 $urandom_range(0, 99) < 35, ra1, DW'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single-port data RAM between two requesters: port 0 is the CPU load/store path, port 1 is a loader/debug DMA port.
- Sits between the requesters and the RAM instance, and drives the RAM's write-enable, address and write-data inputs.
- Supports per-port valid/ready handshakes, registered read responses, and a bounded bus lock for multi-word bursts.

Parameters:
- AW, 32, byte-address width on requester and RAM sides.
- DW, 32, data width.
- MAX_HOLD, 8, maximum cycles a locked owner keeps the RAM while the other port is waiting (1..255).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset (reset==0 at a rising clk edge resets).
- req_valid0 / req_valid1  in  1  request present on port 0 / 1.
- req_we0 / req_we1  in  1  1=write, 0=read.
- req_lock0 / req_lock1  in  1  keep ownership after this access.
- req_addr0 / req_addr1  in  AW  address.
- req_wdata0 / req_wdata1  in  DW  write data.
- req_ready0 / req_ready1  out  1  request accepted this cycle (combinational).
- rsp_valid0 / rsp_valid1  out  1  read data valid (one-cycle pulse).
- rsp_rdata0 / rsp_rdata1  out  DW  read data (registered).
- preempt1_o / preempt0_o  out  1  pulse: the named port's lock was forcibly broken.
- mem_we  out  1  RAM write enable.
- mem_addr  out  AW  RAM address.
- mem_wdata  out  DW  RAM write data.
- mem_rdata  in  DW  RAM read data (combinational read).

Behaviour:
- States: IDLE, OWN0, OWN1. Registers: state, hold_cnt[7:0], last_gnt, rsp_valid0/1, rsp_rdata0/1, preempt0/1.
- Reset values: state=IDLE, hold_cnt=0, last_gnt=1, all rsp_valid=0, all rsp_rdata=0, preempt=0.
- While reset is asserted, req_ready0/1=0 and mem_we=0; any in-flight response is dropped.
- Accept: a transfer happens when req_validN && req_readyN. At most one ready is high per cycle.
- IDLE grant: if only one port is valid, that port is granted. If both are valid, the winner follows the priority rule (see Optional Feature).
- OWNn: only port n may be granted. The other port's ready is 0.
- RAM drive: mem_addr and mem_wdata come from the granted port. mem_we = accept && we. With no grant, mem_we=0 and mem_addr/mem_wdata hold the port 0 values (don't care).
- Read: on an accepted read, mem_rdata is captured into rsp_rdataN at that edge. rsp_validN=1 in the next cycle only. Writes produce no response.
- Back-to-back: a port may be accepted every cycle; read latency is fixed at 1.
- Lock entry: an accept with req_lockN=1 moves the arbiter to OWNn and clears hold_cnt.
- Lock exit: an accept with lock=0 in OWNn returns to IDLE. The next cycle re-arbitrates.
- hold_cnt: in OWNn, increments each cycle the other port is valid and saturates at 255. It resets to 0 on entering OWNn.
- Forced release: when hold_cnt reaches MAX_HOLD in OWNn with the other port valid, the cycle is not granted to n. State goes to IDLE, preemptN pulses for 1 cycle, and the other port wins the next arbitration regardless of priority mode.
- Simultaneous: a forced release takes precedence over an accept by the owner in the same cycle.
- Owner drops valid in OWNn: ownership is kept. hold_cnt counts only while the other port waits.
- last_gnt updates to N on every accept by port N.

Optional Feature:
- Macro: DMEM_ARB_RR_EN.
- Defined: IDLE ties are resolved round-robin, and the port that is not last_gnt wins.
- Undefined: fixed priority, with port 0 (CPU) always winning ties. last_gnt is still maintained but is used only for the forced-release handoff.

Test Plan:
- Reset held low 3 cycles with both ports valid -> ready0=ready1=0, mem_we=0, rsp_valid=0. Release -> port 0 granted first.
- Port 0 writes 0xDEADBEEF @0x10, then reads @0x10 -> mem_we=1 in cycle 1. rsp_valid0=1 with rsp_rdata0=0xDEADBEEF the cycle after the read accept.
- Both ports issue reads every cycle for 4 cycles.
  - Fixed priority -> port 0 granted all 4 cycles.
  - DMEM_ARB_RR_EN -> grants alternate 0,1,0,1.
- Port 1 lock burst: 3 accesses lock=1, then lock=0, while port 0 is idle -> port 1 granted 4 consecutive cycles, then state returns to IDLE.
- Port 1 holds the lock and port 0 is valid continuously, MAX_HOLD=8 -> after 8 waiting cycles preempt1_o pulses once, and port 0 is granted the next cycle.
- Reset asserted the cycle after a read accept -> rsp_valid stays 0 and state returns to IDLE.
